symbol_adjust_detector: RTL and testbench

- Upstream stage of the symbol-adjust reflector datapath; produces the per-lane `symbol_adjust`, with the aligned `symbols` and `res_errors` it consumes.
- Flags likely symbol errors where the energy of two consecutive residual-error samples exceeds a programmable threshold.
- Picks a ±1 adjust from the residual sign, suppresses flags inside a serial holdoff window (which spans frame boundaries), and counts issued corrections.
- Free-running: one frame of `constant_gpack::channel_width` lanes per clock.

---
 rtl/constant_gpack.sv | 4 +
 rtl/error_gpack.sv | 6 +
 rtl/symbol_adjust_detector_pkg.sv | 27 ++
 rtl/symbol_adjust_detector_holdoff_scan.sv | 30 +++
 rtl/symbol_adjust_detector.sv | 131 +++++++++++++
 tb/tb_symbol_adjust_detector.sv | 302 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/constant_gpack.sv
// Project-wide structural constants shared by the reflector datapath.
package constant_gpack;
  localparam int channel_width = 16;
endpackage

// File: rtl/error_gpack.sv
// Precision constants for residual-error processing.
package error_gpack;
  localparam int est_error_precision = 8;
  // Sum of two squared errors always fits without overflow.
  localparam int energy_precision = 2 * est_error_precision + 1;
endpackage

// File: rtl/symbol_adjust_detector_pkg.sv
// Shared types and helpers for the symbol-adjust detector.
package symbol_adjust_detector_pkg;
  localparam int lanes    = constant_gpack::channel_width;
  localparam int err_w    = error_gpack::est_error_precision;
  localparam int energy_w = error_gpack::energy_precision;
  localparam int pop_w    = $clog2(lanes + 1);

  typedef logic [energy_w-1:0]     energy_t;
  typedef logic signed [err_w-1:0] err_t;
  typedef logic [lanes-1:0]        lane_mask_t;
  typedef logic [pop_w-1:0]        pop_t;

  function automatic energy_t pair_energy(input err_t cur, input err_t prev);
    logic signed [energy_w-1:0] c;
    logic signed [energy_w-1:0] p;
    c = energy_w'(cur);
    p = energy_w'(prev);
    return energy_t'(c * c + p * p);
  endfunction

  function automatic pop_t popcount(input lane_mask_t m);
    pop_t n;
    n = '0;
    for (int i = 0; i < lanes; i++) n = n + pop_t'(m[i]);
    return n;
  endfunction
endpackage

// File: rtl/symbol_adjust_detector_holdoff_scan.sv
// Serial holdoff scan over one frame; the countdown carries across frames.
module symbol_adjust_detector_holdoff_scan
  import symbol_adjust_detector_pkg::*;
#(
  parameter int holdoff = 2,
  parameter int hold_w  = 2
) (
  input  lane_mask_t        flags,
  input  logic [hold_w-1:0] hold_cnt,
  output lane_mask_t        accepted,
  output logic [hold_w-1:0] hold_next
);
  localparam logic [hold_w-1:0] hold_load = hold_w'(holdoff);
  localparam logic [hold_w-1:0] hold_one  = hold_w'(1);

  always_comb begin
    logic [hold_w-1:0] c;
    c        = hold_cnt;
    accepted = '0;
    for (int i = 0; i < lanes; i++) begin
      if (c != '0) begin
        c = c - hold_one;
      end else if (flags[i]) begin
        accepted[i] = 1'b1;
        c           = hold_load;
      end
    end
    hold_next = c;
  end
endmodule

// File: rtl/symbol_adjust_detector.sv
// Flags likely symbol errors from two-sample residual energy and issues +/-1 adjusts.
module symbol_adjust_detector
  import symbol_adjust_detector_pkg::*;
#(
  parameter int sym_bitwidth   = 2,
  parameter int holdoff        = 2,
  parameter int count_bitwidth = 16
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic                           en,
  input  logic                           clr_count,
  input  logic [energy_w-1:0]            thresh,
  input  logic [sym_bitwidth-1:0]        symbols_in [lanes],
  input  logic signed [err_w-1:0]        res_errors_in [lanes],
  output logic signed [sym_bitwidth-1:0] symbol_adjust_out [lanes],
  output logic [sym_bitwidth-1:0]        symbols_out [lanes],
  output logic signed [err_w-1:0]        res_errors_out [lanes],
  output logic [count_bitwidth-1:0]      corr_count
);
  localparam int hold_w = (holdoff < 1) ? 1 : $clog2(holdoff + 1);
  localparam int sum_w  = count_bitwidth + 1;
  localparam logic [sym_bitwidth-1:0]        sym_max = '1;
  localparam logic signed [sym_bitwidth-1:0] adj_pos = sym_bitwidth'(1);
  localparam logic signed [sym_bitwidth-1:0] adj_neg = '1;

  // Stage 1 state
  lane_mask_t                    flag_q, dir_q;
  err_t                          prev_err_q;
  logic [sym_bitwidth-1:0]       sym_q1 [lanes];
  err_t                          err_q1 [lanes];
  // Stage 2 state
  logic signed [sym_bitwidth-1:0] adj_q [lanes];
  logic [sym_bitwidth-1:0]        sym_q2 [lanes];
  err_t                           err_q2 [lanes];
  lane_mask_t                     acc_q;
  logic [hold_w-1:0]              hold_cnt;
  logic [count_bitwidth-1:0]      count_q;

  err_t       prev_arr [lanes];
  lane_mask_t flag_d, dir_d, accepted;
  logic [hold_w-1:0] hold_next;
  logic signed [sym_bitwidth-1:0] adj_d [lanes];
  logic [sum_w-1:0] count_sum;

  // Serial predecessor of each lane; lane 0 looks back into the previous frame.
  always_comb begin
    prev_arr[0] = prev_err_q;
    for (int i = 1; i < lanes; i++) prev_arr[i] = res_errors_in[i-1];
  end

  always_comb begin
    flag_d = '0;
    dir_d  = '0;
    for (int i = 0; i < lanes; i++) begin
      dir_d[i]  = ~res_errors_in[i][err_w-1];
      flag_d[i] = en
                  && (pair_energy(res_errors_in[i], prev_arr[i]) > thresh)
                  && (res_errors_in[i] != '0)
                  && !(dir_d[i] && (symbols_in[i] == sym_max))
                  && !(!dir_d[i] && (symbols_in[i] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      flag_q     <= '0;
      dir_q      <= '0;
      prev_err_q <= '0;
      sym_q1     <= '{default: '0};
      err_q1     <= '{default: '0};
    end else begin
      flag_q     <= flag_d;
      dir_q      <= dir_d;
      prev_err_q <= res_errors_in[lanes-1];
      sym_q1     <= symbols_in;
      err_q1     <= res_errors_in;
    end
  end

  symbol_adjust_detector_holdoff_scan #(
    .holdoff (holdoff),
    .hold_w  (hold_w)
  ) holdoff_scan (
    .flags     (flag_q),
    .hold_cnt  (hold_cnt),
    .accepted  (accepted),
    .hold_next (hold_next)
  );

  always_comb begin
    adj_d = '{default: '0};
    for (int i = 0; i < lanes; i++) begin
      if (accepted[i]) adj_d[i] = dir_q[i] ? adj_pos : adj_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      adj_q    <= '{default: '0};
      sym_q2   <= '{default: '0};
      err_q2   <= '{default: '0};
      acc_q    <= '0;
      hold_cnt <= '0;
    end else begin
      adj_q    <= adj_d;
      sym_q2   <= sym_q1;
      err_q2   <= err_q1;
      acc_q    <= accepted;
      hold_cnt <= hold_next;
    end
  end

  // One extra bit catches wrap so the counter can pin at all-ones.
  assign count_sum = {1'b0, count_q} + sum_w'(popcount(acc_q));

  always_ff @(posedge clk) begin
    if (!rstb || clr_count) begin
      count_q <= '0;
    end else if (count_sum[count_bitwidth]) begin
      count_q <= '1;
    end else begin
      count_q <= count_sum[count_bitwidth-1:0];
    end
  end

  assign symbol_adjust_out = adj_q;
  assign symbols_out       = sym_q2;
  assign res_errors_out    = err_q2;
  assign corr_count        = count_q;
endmodule

// File: tb/tb_symbol_adjust_detector.sv
// Self-checking bench for symbol_adjust_detector: table vectors, corner sequences, random stream.
module tb_symbol_adjust_detector;
  localparam int W    = 16;
  localparam int SB   = 2;
  localparam int EB   = 8;
  localparam int EP   = 17;
  localparam int HOLD = 2;
  localparam int CB   = 16;
  localparam int CMAX = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstb, en, clr_count;
  logic [EP-1:0] thresh;
  logic [W*SB-1:0] sym_drv;
  logic [W*EB-1:0] err_drv;

  logic [SB-1:0]        symbols_in [W];
  logic signed [EB-1:0] res_errors_in [W];
  logic signed [SB-1:0] symbol_adjust_out [W];
  logic [SB-1:0]        symbols_out [W];
  logic signed [EB-1:0] res_errors_out [W];
  logic [CB-1:0]        corr_count;

  logic [W*SB-1:0] adj_p, sym_p;
  logic [W*EB-1:0] err_p;

  int total = 0;
  int bad   = 0;

  symbol_adjust_detector #(
    .sym_bitwidth   (SB),
    .holdoff        (HOLD),
    .count_bitwidth (CB)
  ) dut (
    .clk               (clk),
    .rstb              (rstb),
    .en                (en),
    .clr_count         (clr_count),
    .thresh            (thresh),
    .symbols_in        (symbols_in),
    .res_errors_in     (res_errors_in),
    .symbol_adjust_out (symbol_adjust_out),
    .symbols_out       (symbols_out),
    .res_errors_out    (res_errors_out),
    .corr_count        (corr_count)
  );

  always_comb begin
    symbols_in    = '{default: '0};
    res_errors_in = '{default: '0};
    for (int i = 0; i < W; i++) begin
      symbols_in[i]    = sym_drv[i*SB +: SB];
      res_errors_in[i] = err_drv[i*EB +: EB];
    end
  end

  always_comb begin
    adj_p = '0;
    sym_p = '0;
    err_p = '0;
    for (int i = 0; i < W; i++) begin
      adj_p[i*SB +: SB] = symbol_adjust_out[i];
      sym_p[i*SB +: SB] = symbols_out[i];
      err_p[i*EB +: EB] = res_errors_out[i];
    end
  end

  // Reference model: serial stream view of the detector with frame-level latency.
  int m_prev, m_hold, m_count, m_pop;
  int pend_dir [W];
  logic [W*SB-1:0] pend_sym, exp_adj, exp_sym;
  logic [W*EB-1:0] pend_err, exp_err;

  task automatic model_edge();
    int e, p, energy, dir, s;
    if (!rstb) begin
      m_prev = 0; m_hold = 0; m_count = 0; m_pop = 0;
      for (int i = 0; i < W; i++) pend_dir[i] = 0;
      pend_sym = '0; pend_err = '0;
      exp_adj = '0; exp_sym = '0; exp_err = '0;
    end else begin
      if (clr_count) m_count = 0;
      else m_count = (m_count + m_pop > CMAX) ? CMAX : m_count + m_pop;
      exp_adj = '0;
      m_pop = 0;
      for (int i = 0; i < W; i++) begin
        if (m_hold > 0) begin
          m_hold = m_hold - 1;
        end else if (pend_dir[i] != 0) begin
          exp_adj[i*SB +: SB] = (pend_dir[i] > 0) ? 2'b01 : 2'b11;
          m_pop  = m_pop + 1;
          m_hold = HOLD;
        end
      end
      exp_sym = pend_sym;
      exp_err = pend_err;
      for (int i = 0; i < W; i++) begin
        e = signed'(err_drv[i*EB +: EB]);
        if (i == 0) p = m_prev;
        else p = signed'(err_drv[(i-1)*EB +: EB]);
        energy = e * e + p * p;
        s = int'(sym_drv[i*SB +: SB]);
        dir = 0;
        if (en && energy > int'(thresh) && e != 0) dir = (e > 0) ? 1 : -1;
        if (dir == 1 && s == 3) dir = 0;
        if (dir == -1 && s == 0) dir = 0;
        pend_dir[i] = dir;
      end
      m_prev   = signed'(err_drv[(W-1)*EB +: EB]);
      pend_sym = sym_drv;
      pend_err = err_drv;
    end
  endtask

  task automatic check_outputs();
    total++;
    if (adj_p !== exp_adj) begin
      bad++; $display("FAIL adjust: got %h want %h", adj_p, exp_adj);
    end
    total++;
    if (sym_p !== exp_sym) begin
      bad++; $display("FAIL symbols: got %h want %h", sym_p, exp_sym);
    end
    total++;
    if (err_p !== exp_err) begin
      bad++; $display("FAIL errors: got %h want %h", err_p, exp_err);
    end
    total++;
    if (corr_count !== CB'(m_count)) begin
      bad++; $display("FAIL count: got %0d want %0d", corr_count, m_count);
    end
  endtask

  task automatic check_value(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++; $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [W*EB-1:0] le(input int lane, input int val);
    logic [W*EB-1:0] r;
    r = '0;
    r[lane*EB +: EB] = EB'(val);
    return r;
  endfunction

  function automatic logic [W*SB-1:0] la(input int lane, input int dir);
    logic [W*SB-1:0] r;
    r = '0;
    r[lane*SB +: SB] = (dir > 0) ? 2'b01 : 2'b11;
    return r;
  endfunction

  function automatic logic [EB-1:0] rand_err();
    case ($urandom_range(0, 3))
      0:       return '0;
      1, 2:    return EB'(int'($urandom_range(0, 6)) - 3);
      default: return EB'(int'($urandom_range(0, 255)) - 128);
    endcase
  endfunction

  task automatic drive_random();
    for (int i = 0; i < W; i++) begin
      sym_drv[i*SB +: SB] = SB'($urandom_range(0, 3));
      err_drv[i*EB +: EB] = rand_err();
    end
  endtask

  task automatic drive_zero();
    sym_drv = {W{2'b01}};
    err_drv = '0;
    en = 1'b1;
    thresh = '0;
  endtask

  typedef struct {
    string           name;
    logic [W*SB-1:0] syms;
    logic [W*EB-1:0] errs;
    logic [EP-1:0]   thr;
    logic            en;
    logic [W*SB-1:0] adj;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [W*SB-1:0] s;
    logic [W*SB-1:0] saved_sym;

    vecs[0].name = "thresh_edge";
    vecs[0].syms = {W{2'b01}};
    vecs[0].errs = le(3, 6) | le(4, 8) | le(5, 8);
    vecs[0].thr  = EP'(100);
    vecs[0].en   = 1'b1;
    vecs[0].adj  = la(5, 1);

    s = {W{2'b01}};
    s[7*SB +: SB] = 2'd0;
    s[9*SB +: SB] = 2'd2;
    s[12*SB +: SB] = 2'd3;
    vecs[1].name = "sign_guard";
    vecs[1].syms = s;
    vecs[1].errs = le(7, -5) | le(9, -5) | le(12, 5);
    vecs[1].thr  = EP'(10);
    vecs[1].en   = 1'b1;
    vecs[1].adj  = la(9, -1);

    vecs[2].name = "enable_off";
    vecs[2].syms = {W{2'b10}};
    vecs[2].errs = '0;
    for (int i = 0; i < W; i++) vecs[2].errs |= le(i, (i % 2 == 0) ? 100 : -100);
    vecs[2].thr  = '0;
    vecs[2].en   = 1'b0;
    vecs[2].adj  = '0;

    vecs[3].name = "holdoff_runs";
    vecs[3].syms = {W{2'b01}};
    vecs[3].errs = '0;
    for (int i = 0; i < W; i++) vecs[3].errs |= le(i, 1);
    vecs[3].thr  = '0;
    vecs[3].en   = 1'b1;
    vecs[3].adj  = la(0, 1) | la(3, 1) | la(6, 1) | la(9, 1) | la(12, 1) | la(15, 1);

    // Reset with random inputs, then check first post-reset frame alignment.
    rstb = 1'b0; en = 1'b1; clr_count = 1'b0; thresh = EP'(20);
    for (int k = 0; k < 3; k++) begin
      drive_random();
      step();
    end
    rstb = 1'b1;
    drive_random();
    saved_sym = sym_drv;
    step();
    drive_random();
    step();
    check_value("post_reset_symbols", 128'(sym_p), 128'(saved_sym));

    // Table-driven single-frame vectors, isolated by zero frames.
    for (int v = 0; v < 4; v++) begin
      drive_zero(); step(); step();
      sym_drv = vecs[v].syms;
      err_drv = vecs[v].errs;
      thresh  = vecs[v].thr;
      en      = vecs[v].en;
      step();
      drive_zero();
      step();
      check_value(vecs[v].name, 128'(adj_p), 128'(vecs[v].adj));
      step();
    end

    // Holdoff window crossing a frame boundary.
    drive_zero(); step(); step();
    err_drv = le(15, 1);
    step();
    err_drv = le(0, 1) | le(1, 1) | le(2, 1);
    step();
    drive_zero();
    check_value("cross_frame_n", 128'(adj_p), 128'(la(15, 1)));
    step();
    check_value("cross_frame_n1", 128'(adj_p), 128'(la(2, 1)));
    step();

    // Random stream with occasional clears and mid-stream resets.
    for (int k = 0; k < 400; k++) begin
      drive_random();
      en        = ($urandom_range(0, 7) != 0);
      thresh    = ($urandom_range(0, 3) == 0) ? EP'($urandom_range(0, 20000)) : EP'($urandom_range(0, 40));
      clr_count = ($urandom_range(0, 29) == 0);
      rstb      = ($urandom_range(0, 39) != 0);
      step();
    end
    rstb = 1'b1; clr_count = 1'b0;

    // Counter saturation: one accepted flag per frame.
    drive_zero();
    err_drv = le(0, 1);
    for (int k = 0; k < 70000; k++) step();
    check_value("count_saturated", 128'(corr_count), 128'(CMAX));
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    check_value("count_cleared", 128'(corr_count), 128'(0));
    step();
    check_value("count_resumed", 128'(corr_count), 128'(1));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
